jpeg_enc_quant: RTL
===================

Name: jpeg_enc_quant

Overview:
- Quantisation stage directly downstream of the 2-D DCT block.
- After the DCT signals completion, this block reads the 64 18-bit DCT coefficients in natural row-major order and multiplies each by a reciprocal quantiser value from an external table RAM.
- Each product is rounded and saturated to 12 bits, then written in zig-zag order to the quantised-DU RAM consumed by the entropy coder.
- Reports the zig-zag index of the last non-zero coefficient.

Parameters:
- SHIFT, 16, right-shift applied to the product (reciprocal fixed-point fraction bits).
- QW, 16, width of the unsigned reciprocal quantiser value.
- OW, 12, width of the signed quantised output coefficient.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_quant  in  1  start pulse (normally the DCT completion pulse); sampled only in IDLE.
- dctdu_ram_ar  out  6  DCT coefficient RAM read address, natural order {row,col}.
- dctdu_ram_di  in  18  signed DCT coefficient; valid one cycle after the address.
- qtab_a  out  6  reciprocal table address, natural order; always equals dctdu_ram_ar.
- qtab_d  in  QW  unsigned reciprocal (2^SHIFT/q); valid one cycle after the address.
- qdu_ram_aw  out  6  quantised RAM write address (zig-zag index).
- qdu_ram_we  out  1  write enable.
- qdu_ram_do  out  OW  signed quantised coefficient.
- busy  out  1  high whenever state != IDLE.
- last_nz  out  6  highest zig-zag index holding a non-zero value; valid while e_quant is high.
- all_zero  out  1  high if all 64 outputs are zero; valid while e_quant is high.
- e_quant  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0, state IDLE, pipeline valids 0.
- Reset mid-run aborts immediately: no further writes, no e_quant.
- FSM:
  - IDLE -> RUN when s_quant=1.
  - RUN holds 64 cycles; read counter k = 0..63 drives dctdu_ram_ar/qtab_a, then -> FLUSH.
  - FLUSH lasts 3 cycles -> DONE.
  - DONE lasts 1 cycle -> IDLE.
- s_quant is ignored outside IDLE. If s_quant is high in the IDLE cycle following DONE, the next run starts.
- Pipeline, with s_quant sampled at edge 0 (cycle 0):
  - Address k issued in cycle 1+k.
  - S1 (cycle 2+k): register dctdu_ram_di, qtab_d and the index.
  - S2 (cycle 3+k): signed 35-bit product = dct × {1'b0, recip}.
  - S3 (cycle 4+k): round and saturate; outputs registered with qdu_ram_we=1, qdu_ram_aw=ZZ[k].
  - Writes occur in cycles 4..67.
  - e_quant is a flop output, high in cycle 68 only.
  - busy is high in cycles 1..68.
- Arithmetic rules:
  - Rounding is round-half-up: (p + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - The result saturates to [-2^(OW-1), 2^(OW-1)-1] = [-2048, 2047].
  - Saturation is evaluated on the full-width shifted value.
- ZZ is the internal 64-entry constant ROM mapping natural index to standard JPEG zig-zag position. Examples:
  - ZZ[0]=0, ZZ[1]=1, ZZ[8]=2, ZZ[16]=3, ZZ[9]=4, ZZ[2]=5, ZZ[63]=63.
- last_nz / all_zero tracking:
  - A max-tracker resets to 0 and all_zero sets to 1 in the cycle the run starts.
  - On each S3 write with a non-zero value: all_zero <= 0 and tracker <= max(tracker, ZZ[k]).
  - Both values hold after DONE until the next start.
- qdu_ram_we is deasserted in every cycle other than 4..67; qdu_ram_aw and qdu_ram_do hold their last value.
- The block never writes the same zig-zag address twice in one run. Every address 0..63 is written exactly once.

Test Plan:
- All dctdu_ram_di=0, qtab_d=4096 -> 64 writes of 0 covering each address 0..63 once; e_quant in cycle 68; all_zero=1; last_nz=0.
- DC only: dct[0]=1000, qtab_d=4096 -> write aw=0, do=63 (62.5 rounds up); others 0; last_nz=0; all_zero=0. Same with dct[0]=-1000 -> do=-62.
- dct[8]=100, qtab_d=32768 -> write aw=2, do=50 (50.0; 50.5 would round to 51); last_nz=2. dct[63]=64 -> aw=63, do=32, last_nz=63.
- Saturation: dct[5]=131071, qtab_d=65535 -> do=2047; dct[5]=-131072 -> do=-2048.
- Protocol: s_quant pulsed again during RUN -> ignored, exactly 64 writes. s_quant held high -> second run's first address issued in the cycle after the IDLE cycle following DONE.
- Assert reset in cycle 30 -> all outputs 0 next cycle; no e_quant. A fresh s_quant then yields a complete correct 64-write run.

Source files
------------

// File: rtl/jpeg_enc_quant.sv
// JPEG quantiser: reads 64 DCT coefficients in natural order, multiplies by a reciprocal
// quantiser, rounds/saturates to OW bits and writes them in zig-zag order.
module jpeg_enc_quant #(
  parameter int SHIFT = 16,
  parameter int QW    = 16,
  parameter int OW    = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_quant,
  output logic [5:0]           dctdu_ram_ar,
  input  logic signed [17:0]   dctdu_ram_di,
  output logic [5:0]           qtab_a,
  input  logic [QW-1:0]        qtab_d,
  output logic [5:0]           qdu_ram_aw,
  output logic                 qdu_ram_we,
  output logic signed [OW-1:0] qdu_ram_do,
  output logic                 busy,
  output logic [5:0]           last_nz,
  output logic                 all_zero,
  output logic                 e_quant
);

  localparam int PW = 18 + QW + 1;
  localparam logic signed [PW-1:0] HALF = {{(PW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [5:0]            k_q, k_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  e_quant_q, e_quant_d;
  logic                  v1_q, v1_d;
  logic [5:0]            idx1_q, idx1_d;
  logic                  v2_q, v2_d;
  logic [5:0]            idx2_q, idx2_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic                  we_q, we_d;
  logic [5:0]            aw_q, aw_d;
  logic signed [OW-1:0]  do_q, do_d;
  logic [5:0]            last_nz_q, last_nz_d;
  logic                  all_zero_q, all_zero_d;

  logic signed [PW-1:0]  dct_ext, rcp_ext, rnd, shifted;
  logic signed [OW-1:0]  sat;
  logic [5:0]            zz_pos;

  assign dct_ext = {{(PW-18){dctdu_ram_di[17]}}, dctdu_ram_di};
  assign rcp_ext = {{(PW-QW){1'b0}}, qtab_d};

  // The RAM output registers serve as the first pipeline stage, so the product
  // is taken straight from the read data, aligned with idx1.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    fcnt_d    = fcnt_q;
    e_quant_d = 1'b0;
    v1_d      = 1'b0;
    idx1_d    = idx1_q;
    case (state_q)
      IDLE: begin
        if (s_quant) begin
          state_d = RUN;
          k_d     = 6'd0;
        end
      end
      RUN: begin
        v1_d   = 1'b1;
        idx1_d = k_q;
        k_d    = k_q + 6'd1;
        if (k_q == 6'd63) begin
          state_d = FLUSH;
          fcnt_d  = 2'd0;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'd2) begin
          state_d   = DONE;
          e_quant_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    v2_d   = v1_q;
    idx2_d = v1_q ? idx1_q : idx2_q;
    prod_d = dct_ext * rcp_ext;

    // Round half up, then clamp using the full-width shifted value.
    rnd     = prod_q + HALF;
    shifted = rnd >>> SHIFT;
    if (shifted > MAXV)      sat = MAXV[OW-1:0];
    else if (shifted < MINV) sat = MINV[OW-1:0];
    else                     sat = shifted[OW-1:0];
    zz_pos = ZZ[idx2_q];

    we_d = v2_q;
    aw_d = v2_q ? zz_pos : aw_q;
    do_d = v2_q ? sat : do_q;

    last_nz_d  = last_nz_q;
    all_zero_d = all_zero_q;
    if (state_q == IDLE && s_quant) begin
      last_nz_d  = 6'd0;
      all_zero_d = 1'b1;
    end else if (v2_q && sat != '0) begin
      all_zero_d = 1'b0;
      if (zz_pos > last_nz_q) last_nz_d = zz_pos;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      fcnt_q     <= '0;
      e_quant_q  <= 1'b0;
      v1_q       <= 1'b0;
      idx1_q     <= '0;
      v2_q       <= 1'b0;
      idx2_q     <= '0;
      prod_q     <= '0;
      we_q       <= 1'b0;
      aw_q       <= '0;
      do_q       <= '0;
      last_nz_q  <= '0;
      all_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      fcnt_q     <= fcnt_d;
      e_quant_q  <= e_quant_d;
      v1_q       <= v1_d;
      idx1_q     <= idx1_d;
      v2_q       <= v2_d;
      idx2_q     <= idx2_d;
      prod_q     <= prod_d;
      we_q       <= we_d;
      aw_q       <= aw_d;
      do_q       <= do_d;
      last_nz_q  <= last_nz_d;
      all_zero_q <= all_zero_d;
    end
  end

  assign dctdu_ram_ar = k_q;
  assign qtab_a       = k_q;
  assign qdu_ram_we   = we_q;
  assign qdu_ram_aw   = aw_q;
  assign qdu_ram_do   = do_q;
  assign busy         = (state_q != IDLE);
  assign last_nz      = last_nz_q;
  assign all_zero     = all_zero_q;
  assign e_quant      = e_quant_q;

endmodule
